// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment indices, pattern type and the
// active-low glyph table used by every decoder instance.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK  = 7'h7F;
  localparam seg_t SEG_ALL_ON = 7'h00;

  // Active-low {g,f,e,d,c,b,a}; entries 10-15 are the A,b,C,d,E,F glyphs.
  localparam seg_t SEG_DIGIT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_lut.sv
// Combinational digit-to-segment lookup, active-low. Codes above 9 are
// blanked unless hex_mode selects the A-F glyphs.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       hex_mode,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DIGIT[bcd];
    if (bcd > 4'd9 && !hex_mode) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_decoder.sv
// One HEX digit driver: lookup, lamp-test/blank priority, output polarity
// and a registered output so the segments never glitch.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned HEX_MODE   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] leds
);

  localparam logic HEX_EN     = (HEX_MODE != 0);
  localparam seg_t RESET_LEDS = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

  seg_t lut_seg;
  seg_t pick_seg;
  seg_t leds_next;
  seg_t leds_reg;

  seg7_lut u_lut (
    .bcd      (bcd),
    .hex_mode (HEX_EN),
    .seg      (lut_seg)
  );

  always_comb begin
    pick_seg = lut_seg;
    if (lamp_test) begin
      pick_seg = SEG_ALL_ON;
    end else if (blank) begin
      pick_seg = SEG_BLANK;
    end
    leds_next = (ACTIVE_LOW != 0) ? pick_seg : ~pick_seg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds_reg <= RESET_LEDS;
    end else begin
      leds_reg <= leds_next;
    end
  end

  assign leds = leds_reg;

endmodule

// File: tb/tb_seg7_decoder.sv
// Scoreboard bench: three decoder variants share the stimulus; expected
// patterns are queued at issue time and checked one edge later.
module tb_seg7_decoder;

  logic       clk;
  logic       reset_n;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic [6:0] leds_lo;
  logic [6:0] leds_hx;
  logic [6:0] leds_po;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [6:0] lo;
    logic [6:0] hx;
    logic [6:0] po;
  } exp_t;

  exp_t sb[$];

  seg7_decoder #(.ACTIVE_LOW(1), .HEX_MODE(0)) dut_lo (
    .clk(clk), .reset_n(reset_n), .bcd(bcd), .blank(blank),
    .lamp_test(lamp_test), .leds(leds_lo));

  seg7_decoder #(.ACTIVE_LOW(1), .HEX_MODE(1)) dut_hx (
    .clk(clk), .reset_n(reset_n), .bcd(bcd), .blank(blank),
    .lamp_test(lamp_test), .leds(leds_hx));

  seg7_decoder #(.ACTIVE_LOW(0), .HEX_MODE(0)) dut_po (
    .clk(clk), .reset_n(reset_n), .bcd(bcd), .blank(blank),
    .lamp_test(lamp_test), .leds(leds_po));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: leds=%h expected %h", name, got, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [6:0] lo, input logic [6:0] hx,
                      input logic [6:0] po);
    chk({name, "/lo"}, leds_lo, lo);
    chk({name, "/hex"}, leds_hx, hx);
    chk({name, "/pos"}, leds_po, po);
    $display("txn %-12s lo=%h hex=%h pos=%h (exp %h %h %h)", name,
             leds_lo, leds_hx, leds_po, lo, hx, po);
  endtask

  // Caller must already be at a negedge; hx is the HEX_MODE=1 expectation.
  task automatic apply(input string name, input logic [3:0] b, input logic bl,
                       input logic lt, input logic [6:0] lo, input logic [6:0] hx);
    exp_t e;
    bcd = b;
    blank = bl;
    lamp_test = lt;
    e.name = name;
    e.lo = lo;
    e.hx = hx;
    e.po = ~lo;
    sb.push_back(e);
  endtask

  // Monitor: every rising edge presents a result for the previous inputs.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk3(e.name, e.lo, e.hx, e.po);
    end
  end

  logic [6:0] dig_lo [0:15];
  logic [6:0] dig_hx [0:15];

  initial begin
    dig_lo = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    dig_hx = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    reset_n = 1'b0;
    bcd = 4'd8;
    blank = 1'b0;
    lamp_test = 1'b0;

    // Reset holds blank across clock edges.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk3("reset_hold", 7'h7F, 7'h7F, 7'h00);
    end

    @(negedge clk);
    reset_n = 1'b1;
    apply("release_8", 4'd8, 1'b0, 1'b0, 7'h00, 7'h00);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply($sformatf("digit_%0d", i), 4'(i), 1'b0, 1'b0, dig_lo[i], dig_hx[i]);
    end

    @(negedge clk); apply("prio_blank", 4'd3, 1'b1, 1'b0, 7'h7F, 7'h7F);
    @(negedge clk); apply("prio_lamp",  4'd3, 1'b1, 1'b1, 7'h00, 7'h00);
    @(negedge clk); apply("prio_lamp_only", 4'd12, 1'b0, 1'b1, 7'h00, 7'h00);
    @(negedge clk); apply("prio_none",  4'd3, 1'b0, 1'b0, 7'h30, 7'h30);
    @(negedge clk); apply("blank_1",    4'd1, 1'b1, 1'b0, 7'h7F, 7'h7F);
    @(negedge clk); apply("pol_1",      4'd1, 1'b0, 1'b0, 7'h79, 7'h79);

    // Score 205 shown digit by digit: hundreds, tens, ones.
    @(negedge clk); apply("score_h2",   4'd2, 1'b0, 1'b0, 7'h24, 7'h24);
    @(negedge clk); apply("score_h1",   4'd0, 1'b0, 1'b0, 7'h40, 7'h40);
    @(negedge clk); apply("score_h0",   4'd5, 1'b0, 1'b0, 7'h12, 7'h12);

    // Asynchronous reset between edges while showing 5.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk3("async_reset", 7'h7F, 7'h7F, 7'h00);
    @(posedge clk);
    #1;
    chk3("reset_edge", 7'h7F, 7'h7F, 7'h00);

    @(negedge clk);
    reset_n = 1'b1;
    apply("rerelease_7", 4'd7, 1'b0, 1'b0, 7'h78, 7'h78);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
- Converts one 4-bit BCD digit into a 7-segment drive pattern for one HEX display.
- Three instances sit under the score display block: hundreds, tens and ones digits.
- Output is registered, giving one cycle of latency and glitch-free segment drive.
- Codes 10-15 are blanked by default; optional hex mode shows A-F instead.

Parameters:
- ACTIVE_LOW, 1, 1 = segment on is driven as 0 (board HEX polarity); 0 = all outputs inverted.
- HEX_MODE, 0, 0 = codes 10-15 blank; 1 = codes 10-15 show A, b, C, d, E, F.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bcd  input  4  digit to display, 0-15.
- blank  input  1  1 = all segments off (leading-zero suppression by the parent).
- lamp_test  input  1  1 = all segments on.
- leds  output  7  segment drive; leds[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.

Behaviour:
- One clock, clk; reset is asynchronous and active-low (reset_n).
- Reset: while reset_n=0, leds is immediately the blank pattern (7'h7F when ACTIVE_LOW=1, 7'h00 otherwise), independent of clk. The first update happens on the first rising clk edge after reset_n is released.
- Latency: leds on the edge after inputs are sampled reflects those inputs. Exactly 1 cycle, no handshake; a new digit can be accepted every cycle.
- Priority: lamp_test > blank > decode.
  - lamp_test=1 gives all segments on (7'h00 active-low).
  - blank=1 with lamp_test=0 gives all segments off (7'h7F).
- Decode table, active-low, written as hex of {g,f,e,d,c,b,a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Codes 10-15:
  - HEX_MODE=0: blank (7F).
  - HEX_MODE=1: A=08, b=03, C=46, d=21, E=06, F=0E.
- ACTIVE_LOW=0: every pattern above, including the reset and blank values, is bitwise inverted.
- X/Z on bcd is not required to be handled; 4-bit inputs cover all 16 codes, with no wrap-around or overflow cases.
- Reset asserted mid-operation: output goes to blank asynchronously and stays blank until reset_n releases and a clock edge occurs.
- blank and lamp_test are sampled on the same edge as bcd; simultaneous changes take effect together.

Decomposition:
- Shared package seg7_pkg holds:
  - segment-index constants SEG_A..SEG_G;
  - typedef seg_t (logic [6:0]);
  - localparam active-low patterns SEG_DIGIT[0:15] (10-15 = hex glyphs), SEG_BLANK=7'h7F, SEG_ALL_ON=7'h00.
- One combinational sub-module, seg7_lut (bcd, hex_mode -> seg_t active-low), does the table lookup.
- The top applies the priority mux, the polarity inversion and the output register.

Test Plan:
- Reset: hold reset_n=0 with bcd=8 and toggle clk -> leds=7F throughout. Release reset_n; after 1 edge -> leds=00.
- Digit sweep: bcd=0..9, one per cycle, blank=0, lamp_test=0 -> leds = 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, each one cycle after its input.
- Out-of-range codes: bcd=10..15 with HEX_MODE=0 -> 7F each. Same sweep with HEX_MODE=1 -> 08, 03, 46, 21, 06, 0E.
- Priority: bcd=3, blank=1 -> 7F; add lamp_test=1 -> 00; drop both -> 30. Each result appears one cycle after its input change.
- Async reset mid-stream: bcd=5 with leds=12, then pull reset_n low between edges -> leds=7F before the next edge.
- Polarity: ACTIVE_LOW=0 instance with bcd=1 -> 06; with blank=1 -> 00. Parent scenario: score 0..255 decomposed into three digits, e.g. score=205 -> HEX2=24, HEX1=40, HEX0=12.
